// File: rtl/keypad_pkg.sv
// keypad_pkg: key map, FSM states and counter sizing shared by the keypad
// emulator and the keypad scanner so both ends agree on the matrix wiring.
package keypad_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HOLD,
        ST_BOUNCE_OUT,
        ST_GAP
    } state_t;

    // Row r = key[3:2] is driven by strobe bit (3-r).
    function automatic logic [1:0] key_to_strobe_bit(input logic [KEY_W-1:0] key);
        return 2'(NUM_ROWS - 1) - key[3:2];
    endfunction

    // Column c = key[1:0] is reported on row_sense bit c.
    function automatic logic [NUM_COLS-1:0] key_to_row_onehot(input logic [KEY_W-1:0] key);
        return NUM_COLS'(1) << key[1:0];
    endfunction

    // Width able to count 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/keypad_contact_bounce.sv
// keypad_contact_bounce: contact chatter generator; starts at init_level and
// inverts every BOUNCE_TOGGLE cycles for BOUNCE_LEN cycles after start.
module keypad_contact_bounce
    import keypad_pkg::*;
#(
    parameter int BOUNCE_LEN    = 8,
    parameter int BOUNCE_TOGGLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic init_level,
    output logic contact_bounce,
    output logic bounce_done
);

    localparam int CW = cnt_w(BOUNCE_LEN);
    localparam int TW = cnt_w(BOUNCE_TOGGLE);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tog;
    logic          r_level;
    logic          w_flip;

    assign w_flip         = r_tog == TW'(BOUNCE_TOGGLE - 1);
    assign bounce_done    = r_active && (r_cnt == CW'(BOUNCE_LEN - 1));
    assign contact_bounce = r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_tog    <= '0;
            r_level  <= 1'b0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_tog    <= '0;
            r_level  <= init_level;
        end else if (r_active) begin
            r_active <= !bounce_done;
            r_cnt    <= r_cnt + 1'b1;
            r_tog    <= w_flip ? '0 : r_tog + 1'b1;
            r_level  <= r_level ^ w_flip;
        end
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: passive 4x4 keypad model; plays press commands as
// bounce / hold / release bounce / gap and answers the scanner's column strobes.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_W        = 16,
    parameter int BOUNCE_LEN    = 8,
    parameter int BOUNCE_TOGGLE = 2,
    parameter int GAP_LEN       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        scan_strobe,
    output logic [3:0]        row_sense,
    output logic              busy,
    output logic              done,
    output logic [KEY_W-1:0]  cur_key
);

    localparam int  GW     = cnt_w(GAP_LEN);
    localparam bit  HAS_BN = BOUNCE_LEN > 0;

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [GW-1:0]     r_gap;
    logic              r_busy;
    logic              r_done;
    logic [KEY_W-1:0]  r_key;

    logic w_accept;
    logic w_hold_last;
    logic w_gap_last;
    logic w_start_in;
    logic w_start_out;
    logic w_bounce;
    logic w_bounce_done;
    logic w_contact;

    assign cmd_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_hold_last = (r_state == ST_HOLD) && (r_hold == '0);
    assign w_gap_last  = r_gap == GW'(GAP_LEN > 0 ? GAP_LEN - 1 : 0);
    assign w_start_in  = w_accept && HAS_BN;
    assign w_start_out = w_hold_last && HAS_BN;

    keypad_contact_bounce #(
        .BOUNCE_LEN    (BOUNCE_LEN),
        .BOUNCE_TOGGLE (BOUNCE_TOGGLE)
    ) u_bounce (
        .clk            (clk),
        .rst            (rst),
        .start          (w_start_in || w_start_out),
        .init_level     (w_start_in),
        .contact_bounce (w_bounce),
        .bounce_done    (w_bounce_done)
    );

    always_comb begin
        w_contact = (r_state == ST_HOLD) ||
                    (((r_state == ST_BOUNCE_IN) || (r_state == ST_BOUNCE_OUT)) && w_bounce);
        row_sense = (w_contact && scan_strobe[key_to_strobe_bit(r_key)]) ?
                    key_to_row_onehot(r_key) : 4'b0000;
    end

    // done is raised on the last gap cycle and the FSM lingers one more cycle
    // in GAP so cmd_ready only returns after the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_gap   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_key   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_key   <= cmd_key;
                    r_hold  <= (cmd_hold == '0) ? '0 : cmd_hold - 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= HAS_BN ? ST_BOUNCE_IN : ST_HOLD;
                end
                ST_BOUNCE_IN: if (w_bounce_done) r_state <= ST_HOLD;
                ST_HOLD: if (w_hold_last) begin
                    r_state <= HAS_BN ? ST_BOUNCE_OUT : ST_GAP;
                    r_gap   <= '0;
                end else begin
                    r_hold <= r_hold - 1'b1;
                end
                ST_BOUNCE_OUT: if (w_bounce_done) begin
                    r_state <= ST_GAP;
                    r_gap   <= '0;
                end
                ST_GAP: if (r_done) begin
                    r_state <= ST_IDLE;
                end else if (w_gap_last) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign cur_key = r_key;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// tb_keypad_matrix_emulator: two emulators (bounce on / bounce off) driven by a
// shared command stream and compared every cycle against a timeline model.
module tb_keypad_matrix_emulator;

    localparam int TOG = 2;
    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_key = '0;
    logic [15:0] cmd_hold = '0;
    logic [3:0]  scan_strobe = '0;

    logic [1:0]  ready, busy, done;
    logic [3:0]  rs [2];
    logic [3:0]  ck [2];

    int n_checks = 0;
    int n_errors = 0;

    int m_act [2] = '{0, 0};
    int m_off [2] = '{0, 0};
    int m_h   [2] = '{0, 0};
    int m_key [2] = '{0, 0};
    int c_exp, r_exp, lo;

    always #5 clk = ~clk;

    keypad_matrix_emulator #(.HOLD_W(16), .BOUNCE_LEN(8), .BOUNCE_TOGGLE(TOG), .GAP_LEN(GAP)) u_dut_bn (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready[0]),
        .cmd_key(cmd_key), .cmd_hold(cmd_hold), .scan_strobe(scan_strobe),
        .row_sense(rs[0]), .busy(busy[0]), .done(done[0]), .cur_key(ck[0])
    );

    keypad_matrix_emulator #(.HOLD_W(16), .BOUNCE_LEN(0), .BOUNCE_TOGGLE(TOG), .GAP_LEN(GAP)) u_dut_nb (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready[1]),
        .cmd_key(cmd_key), .cmd_hold(cmd_hold), .scan_strobe(scan_strobe),
        .row_sense(rs[1]), .busy(busy[1]), .done(done[1]), .cur_key(ck[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bl_of(input int d);
        return (d == 0) ? 8 : 0;
    endfunction

    // Offset (cycles after accept) of the done pulse.
    function automatic int done_off(input int d);
        return 2 * bl_of(d) + m_h[d] + GAP + 1;
    endfunction

    // Contact level at offset o after accept: press chatter, hold, release chatter, gap.
    function automatic int exp_contact(input int o, input int h, input int bl);
        if (o <= bl) return int'(((o - 1) / TOG) % 2 == 0);
        if (o <= bl + h) return 1;
        if (o <= 2 * bl + h) return int'(((o - bl - h - 1) / TOG) % 2 == 1);
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] <= 0;
                m_key[d] <= 0;
            end else if (m_act[d] != 0) begin
                if (m_off[d] == done_off(d)) m_act[d] <= 0;
                else m_off[d] <= m_off[d] + 1;
            end else if (cmd_valid) begin
                m_act[d] <= 1;
                m_off[d] <= 1;
                m_key[d] <= int'(cmd_key);
                m_h[d]   <= (cmd_hold == 0) ? 1 : int'(cmd_hold);
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            lo    = done_off(d);
            c_exp = (m_act[d] != 0) ? exp_contact(m_off[d], m_h[d], bl_of(d)) : 0;
            r_exp = (c_exp != 0 && scan_strobe[3 - m_key[d] / 4]) ? (1 << (m_key[d] % 4)) : 0;
            check($sformatf("row_sense%0d", d), int'(rs[d]), r_exp);
            check($sformatf("done%0d", d), int'(done[d]), int'(m_act[d] != 0 && m_off[d] == lo));
            check($sformatf("busy%0d", d), int'(busy[d]), int'(m_act[d] != 0 && m_off[d] < lo));
            check($sformatf("cmd_ready%0d", d), int'(ready[d]), int'(m_act[d] == 0 && !rst));
            check($sformatf("cur_key%0d", d), int'(ck[d]), m_key[d]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int key, input int hold, input logic [3:0] strobe, input int wait_cyc);
        cmd_key     = 4'(key);
        cmd_hold    = 16'(hold);
        scan_strobe = strobe;
        cmd_valid   = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        step(wait_cyc);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);
        // key 0 with cmd_valid held: back-to-back accepts
        cmd_key = 4'd0; cmd_hold = 16'd100; scan_strobe = 4'b1000; cmd_valid = 1'b1;
        step(300);
        cmd_valid = 1'b0;
        step(160);
        // key 5 under a walking strobe
        cmd_key = 4'd5; cmd_hold = 16'd20; cmd_valid = 1'b1;
        for (int i = 0; i < 160; i++) begin
            scan_strobe = 4'b1000 >> (i % 4);
            step(1);
        end
        cmd_valid = 1'b0;
        step(60);
        // reset in the middle of key 15's hold
        press(15, 200, 4'b0001, 40);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        press(3, 0, 4'b1000, 60);
        press(12, 1, 4'b1111, 60);
        for (int i = 0; i < 3000; i++) begin
            cmd_valid   = ($urandom % 3) == 0;
            cmd_key     = 4'($urandom);
            cmd_hold    = 16'($urandom % 40);
            scan_strobe = ($urandom % 2 == 0) ? (4'b0001 << ($urandom % 4)) : 4'($urandom);
            rst         = ($urandom % 400) == 0;
            step(1);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        step(60);
        press(10, 16'hFFFF, 4'b0011, 65620);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
